// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding-select and load-use hazard controller for the pipelined CPU.
// Define HAZ_PERF_CNT_EN to add saturating stall_cnt / fwd_cnt event counters.
module fwd_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic             id_rn_used,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_rm_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    output logic             stall,
    output logic             ex_a_fwd,
    output logic             ex_a_src,
    output logic             ex_b_fwd,
    output logic             ex_b_src
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      fwd_cnt
`endif
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    // A source hits a slot when the slot writes a real register that the source reads.
    function automatic logic src_hit(input logic             valid,
                                     input logic             regwrite,
                                     input logic [REG_W-1:0] rd,
                                     input logic             used,
                                     input logic [REG_W-1:0] idx);
        return valid && regwrite && (rd != ZR) && used && (idx == rd);
    endfunction

    // The WB record is not kept: nothing that has left MEM is forwarded into EX.
    logic             ex_valid_r, ex_regwrite_r, ex_memread_r;
    logic [REG_W-1:0] ex_rd_r;
    logic             mem_valid_r, mem_regwrite_r, mem_memread_r;
    logic [REG_W-1:0] mem_rd_r;

    logic a_ex_hit_s, a_mem_hit_s, b_ex_hit_s, b_mem_hit_s;
    logic ex_load_s, stall_s;
    logic a_fwd_nxt_s, a_src_nxt_s, b_fwd_nxt_s, b_src_nxt_s;

    // Hazard detection and next-cycle forwarding selects from the pre-edge slots.
    always_comb begin
        a_ex_hit_s  = src_hit(ex_valid_r,  ex_regwrite_r,  ex_rd_r,  id_rn_used, id_rn);
        a_mem_hit_s = src_hit(mem_valid_r, mem_regwrite_r, mem_rd_r, id_rn_used, id_rn);
        b_ex_hit_s  = src_hit(ex_valid_r,  ex_regwrite_r,  ex_rd_r,  id_rm_used, id_rm);
        b_mem_hit_s = src_hit(mem_valid_r, mem_regwrite_r, mem_rd_r, id_rm_used, id_rm);
        ex_load_s   = ex_valid_r && ex_regwrite_r && ex_memread_r && (ex_rd_r != ZR);
        if (id_valid && ex_load_s && !flush && !freeze) begin
            stall_s = a_ex_hit_s || b_ex_hit_s;
        end else begin
            stall_s = 1'b0;
        end
        // A load leaving MEM delivers its data on the memory output, not on WriteData.
        if (id_valid) begin
            a_fwd_nxt_s = a_ex_hit_s || a_mem_hit_s;
            a_src_nxt_s = !a_ex_hit_s && a_mem_hit_s && !mem_memread_r;
            b_fwd_nxt_s = b_ex_hit_s || b_mem_hit_s;
            b_src_nxt_s = !b_ex_hit_s && b_mem_hit_s && !mem_memread_r;
        end else begin
            a_fwd_nxt_s = 1'b0;
            a_src_nxt_s = 1'b0;
            b_fwd_nxt_s = 1'b0;
            b_src_nxt_s = 1'b0;
        end
    end

    assign stall = stall_s;

    // Slot shift register and registered forwarding selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r     <= 1'b0;
            ex_regwrite_r  <= 1'b0;
            ex_memread_r   <= 1'b0;
            ex_rd_r        <= {REG_W{1'b0}};
            mem_valid_r    <= 1'b0;
            mem_regwrite_r <= 1'b0;
            mem_memread_r  <= 1'b0;
            mem_rd_r       <= {REG_W{1'b0}};
            ex_a_fwd       <= 1'b0;
            ex_a_src       <= 1'b0;
            ex_b_fwd       <= 1'b0;
            ex_b_src       <= 1'b0;
        end else if (!freeze) begin
            mem_valid_r    <= ex_valid_r;
            mem_regwrite_r <= ex_regwrite_r;
            mem_memread_r  <= ex_memread_r;
            mem_rd_r       <= ex_rd_r;
            if (flush || stall_s) begin
                ex_valid_r    <= 1'b0;
                ex_regwrite_r <= 1'b0;
                ex_memread_r  <= 1'b0;
                ex_a_fwd      <= 1'b0;
                ex_a_src      <= 1'b0;
                ex_b_fwd      <= 1'b0;
                ex_b_src      <= 1'b0;
            end else begin
                ex_valid_r    <= id_valid;
                ex_regwrite_r <= id_regwrite;
                ex_memread_r  <= id_memread;
                ex_rd_r       <= id_rd;
                ex_a_fwd      <= a_fwd_nxt_s;
                ex_a_src      <= a_src_nxt_s;
                ex_b_fwd      <= b_fwd_nxt_s;
                ex_b_src      <= b_src_nxt_s;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic accept_fwd_s;
    assign accept_fwd_s = id_valid && !flush && !stall_s && (a_fwd_nxt_s || b_fwd_nxt_s);

    // Saturating event counters; freeze already forces stall_s low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            fwd_cnt   <= 32'd0;
        end else if (!freeze) begin
            if (stall_s && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (accept_fwd_s && (fwd_cnt != 32'hFFFF_FFFF)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: per-scenario stimulus tables, expected selects queued per step.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, freeze, flush, id_valid, id_rn_used, id_rm_used, id_regwrite, id_memread;
    logic [4:0] id_rn, id_rm, id_rd;
    logic       stall, ex_a_fwd, ex_a_src, ex_b_fwd, ex_b_src;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    int n_cmp = 0;
    int n_mis = 0;
    logic [3:0] exp_q [$];

    typedef struct packed {
        logic       v;
        logic [4:0] rn;
        logic       rnu;
        logic [4:0] rm;
        logic       rmu;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic       fz;
        logic       es;
        logic [3:0] eo;
    } step_t;

    fwd_hazard_ctrl #(.REG_W(5), .ZERO_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_rn(id_rn), .id_rn_used(id_rn_used),
        .id_rm(id_rm), .id_rm_used(id_rm_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .stall(stall), .ex_a_fwd(ex_a_fwd), .ex_a_src(ex_a_src),
        .ex_b_fwd(ex_b_fwd), .ex_b_src(ex_b_src)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Row: valid, rn, rn_used, rm, rm_used, rd, regwrite, memread, flush, freeze, stall, {a_fwd,a_src,b_fwd,b_src}
    function automatic step_t mk(input int v, input int rn, input int rnu, input int rm, input int rmu,
                                 input int rd, input int rw, input int mr, input int fl, input int fz,
                                 input int es, input logic [3:0] eo);
        step_t s;
        s.v = 1'(v);   s.rn = 5'(rn); s.rnu = 1'(rnu); s.rm = 5'(rm); s.rmu = 1'(rmu);
        s.rd = 5'(rd); s.rw = 1'(rw); s.mr = 1'(mr);   s.fl = 1'(fl); s.fz = 1'(fz);
        s.es = 1'(es); s.eo = eo;
        return s;
    endfunction

    function automatic logic [3:0] sel_obs();
        return {ex_a_fwd, ex_a_src, ex_b_fwd, ex_b_src};
    endfunction

    task automatic apply(input step_t s);
        id_valid = s.v;  id_rn = s.rn; id_rn_used = s.rnu; id_rm = s.rm; id_rm_used = s.rmu;
        id_rd = s.rd;    id_regwrite = s.rw; id_memread = s.mr; flush = s.fl; freeze = s.fz;
    endtask

    task automatic drain(inout step_t st [$]);
        for (int i = 0; i < 3; i++) st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        #3;
        n_cmp++;
        if (sel_obs() !== 4'b0000) begin
            n_mis++; $display("FAIL reset_outputs: got %b expected %b", sel_obs(), 4'b0000);
        end
        apply(mk(1, 9, 1, 9, 1, 10, 1, 0, 0, 0, 0, 4'b0000));
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_mis++; $display("FAIL reset_stall: got %b expected %b", stall, 1'b0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (sel_obs() !== 4'b0000) begin
            n_mis++; $display("FAIL reset_hold: got %b expected %b", sel_obs(), 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ex_fwd();
        step_t st [$];
        logic [3:0] e;
        drain(st);
        st.push_back(mk(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 4'b0000));   // ADD X1,X2,X3
        st.push_back(mk(1, 1, 1, 5, 1, 4, 1, 0, 0, 0, 0, 4'b1000));   // SUB X4,X1,X5
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk); apply(st[i]); #1;
            n_cmp++;
            if (stall !== st[i].es) begin
                n_mis++; $display("FAIL ex_fwd[%0d] stall: got %b expected %b", i, stall, st[i].es);
            end
            exp_q.push_back(st[i].eo);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (sel_obs() !== e) begin
                n_mis++; $display("FAIL ex_fwd[%0d] selects: got %b expected %b", i, sel_obs(), e);
            end
        end
    endtask

    task automatic test_mem_fwd();
        step_t st [$];
        logic [3:0] e;
        drain(st);
        st.push_back(mk(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 4'b0000));   // ADD X1,X2,X3
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));   // NOP
        st.push_back(mk(1, 7, 1, 1, 1, 6, 1, 0, 0, 0, 0, 4'b0011));   // ORR X6,X7,X1
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk); apply(st[i]); #1;
            n_cmp++;
            if (stall !== st[i].es) begin
                n_mis++; $display("FAIL mem_fwd[%0d] stall: got %b expected %b", i, stall, st[i].es);
            end
            exp_q.push_back(st[i].eo);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (sel_obs() !== e) begin
                n_mis++; $display("FAIL mem_fwd[%0d] selects: got %b expected %b", i, sel_obs(), e);
            end
        end
    endtask

    task automatic test_load_use();
        step_t st [$];
        logic [3:0] e;
        drain(st);
        st.push_back(mk(1, 0, 1, 0, 0, 9, 1, 1, 0, 0, 0, 4'b0000));    // LDUR X9,[X0]
        st.push_back(mk(1, 9, 1, 9, 1, 10, 1, 0, 0, 0, 1, 4'b0000));   // ADD X10,X9,X9 stalls
        st.push_back(mk(1, 9, 1, 9, 1, 10, 1, 0, 0, 0, 0, 4'b1010));   // re-presented, forwarded
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk); apply(st[i]); #1;
            n_cmp++;
            if (stall !== st[i].es) begin
                n_mis++; $display("FAIL load_use[%0d] stall: got %b expected %b", i, stall, st[i].es);
            end
            exp_q.push_back(st[i].eo);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (sel_obs() !== e) begin
                n_mis++; $display("FAIL load_use[%0d] selects: got %b expected %b", i, sel_obs(), e);
            end
        end
    endtask

    task automatic test_zero_reg();
        step_t st [$];
        logic [3:0] e;
        drain(st);
        st.push_back(mk(1, 1, 1, 2, 1, 31, 1, 0, 0, 0, 0, 4'b0000));   // ADD X31,X1,X2
        st.push_back(mk(1, 31, 1, 31, 1, 3, 1, 0, 0, 0, 0, 4'b0000));  // ADD X3,X31,X31
        st.push_back(mk(1, 0, 1, 0, 0, 31, 1, 1, 0, 0, 0, 4'b0000));   // LDUR X31,[X0]
        st.push_back(mk(1, 31, 1, 31, 1, 4, 1, 0, 0, 0, 0, 4'b0000));  // ADD X4,X31,X31
        st.push_back(mk(1, 4, 0, 4, 0, 6, 1, 0, 0, 0, 0, 4'b0000));    // X4 named but not read
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk); apply(st[i]); #1;
            n_cmp++;
            if (stall !== st[i].es) begin
                n_mis++; $display("FAIL zero_reg[%0d] stall: got %b expected %b", i, stall, st[i].es);
            end
            exp_q.push_back(st[i].eo);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (sel_obs() !== e) begin
                n_mis++; $display("FAIL zero_reg[%0d] selects: got %b expected %b", i, sel_obs(), e);
            end
        end
    endtask

    task automatic test_flush();
        step_t st [$];
        logic [3:0] e;
        drain(st);
        st.push_back(mk(1, 0, 1, 0, 0, 9, 1, 1, 0, 0, 0, 4'b0000));    // LDUR X9,[X0]
        st.push_back(mk(1, 9, 1, 9, 1, 10, 1, 0, 1, 0, 0, 4'b0000));   // hazard + flush
        st.push_back(mk(1, 9, 1, 2, 1, 11, 1, 0, 0, 0, 0, 4'b1000));   // ADD X11,X9,X2
        st.push_back(mk(1, 11, 1, 11, 1, 12, 1, 0, 1, 0, 0, 4'b0000)); // would forward, flushed
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk); apply(st[i]); #1;
            n_cmp++;
            if (stall !== st[i].es) begin
                n_mis++; $display("FAIL flush[%0d] stall: got %b expected %b", i, stall, st[i].es);
            end
            exp_q.push_back(st[i].eo);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (sel_obs() !== e) begin
                n_mis++; $display("FAIL flush[%0d] selects: got %b expected %b", i, sel_obs(), e);
            end
        end
    endtask

    task automatic test_freeze();
        step_t st [$];
        logic [3:0] e;
        drain(st);
        st.push_back(mk(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 4'b0000));    // ADD X1,X2,X3
        st.push_back(mk(1, 1, 1, 5, 1, 4, 1, 0, 0, 0, 0, 4'b1000));    // SUB X4,X1,X5
        for (int k = 0; k < 3; k++)
            st.push_back(mk(1, 1, 1, 4, 1, 6, 1, 0, 0, 1, 0, 4'b1000)); // frozen, selects held
        st.push_back(mk(1, 1, 1, 4, 1, 6, 1, 0, 0, 0, 0, 4'b1110));    // ORR X6,X1,X4
        st.push_back(mk(1, 6, 1, 4, 1, 7, 1, 0, 0, 0, 0, 4'b1011));    // AND X7,X6,X4
        st.push_back(mk(1, 0, 1, 0, 0, 9, 1, 1, 0, 0, 0, 4'b0000));    // LDUR X9,[X0]
        st.push_back(mk(1, 9, 1, 9, 1, 10, 1, 0, 0, 1, 0, 4'b0000));   // hazard under freeze
        st.push_back(mk(1, 9, 1, 9, 1, 10, 1, 0, 0, 0, 1, 4'b0000));   // hazard released
        st.push_back(mk(1, 9, 1, 9, 1, 10, 1, 0, 0, 0, 0, 4'b1010));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk); apply(st[i]); #1;
            n_cmp++;
            if (stall !== st[i].es) begin
                n_mis++; $display("FAIL freeze[%0d] stall: got %b expected %b", i, stall, st[i].es);
            end
            exp_q.push_back(st[i].eo);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (sel_obs() !== e) begin
                n_mis++; $display("FAIL freeze[%0d] selects: got %b expected %b", i, sel_obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t st [$];
        logic [3:0] e;
        drain(st);
        st.push_back(mk(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 4'b0000));    // ADD X1,X2,X3
        st.push_back(mk(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 4'b1010));    // ADD X2,X1,X1
        st.push_back(mk(1, 2, 1, 1, 1, 3, 1, 0, 0, 0, 0, 4'b1011));    // ADD X3,X2,X1
        st.push_back(mk(1, 1, 1, 1, 1, 4, 1, 0, 0, 0, 0, 4'b0000));    // after reset: SUB X4,X1,X1
        st.push_back(mk(1, 4, 1, 3, 1, 5, 1, 0, 0, 0, 0, 4'b1000));    // ADD X5,X4,X3
        for (int i = 0; i < st.size(); i++) begin
            if (i == 6) begin
                @(negedge clk);
                apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
                #2 rst_n = 1'b0;
                #1;
                n_cmp++;
                if (sel_obs() !== 4'b0000) begin
                    n_mis++; $display("FAIL reset_mid async: got %b expected %b", sel_obs(), 4'b0000);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk); apply(st[i]); #1;
            n_cmp++;
            if (stall !== st[i].es) begin
                n_mis++; $display("FAIL reset_mid[%0d] stall: got %b expected %b", i, stall, st[i].es);
            end
            exp_q.push_back(st[i].eo);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (sel_obs() !== e) begin
                n_mis++; $display("FAIL reset_mid[%0d] selects: got %b expected %b", i, sel_obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ex_fwd();
        test_mem_fwd();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_freeze();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
